// File: rtl/data_bus_pkg.sv
// rtl/data_bus_pkg.sv - address map, status bit positions and UART state type for data_bus
package data_bus_pkg;

    localparam logic [29:0] UART_DATA_ADDR = 30'h2000_0000;
    localparam logic [29:0] UART_STAT_ADDR = 30'h2000_0001;
    localparam logic [29:0] CYCLES_ADDR    = 30'h2000_0002;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_FULL  = 2;
    localparam int STAT_OVF   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/data_bus_uart_tx.sv
// rtl/data_bus_uart_tx.sv - UART transmitter: byte FIFO feeding an 8N1 serializer
module data_bus_uart_tx
    import data_bus_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    output logic       full,
    output logic       empty,
    output logic [7:0] count,
    output logic       busy,
    output logic       tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] DEPTH_FULL = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;

    uart_state_t   state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          tx_reg;

    logic push_ok;
    logic pop;

    assign full  = (fifo_count == DEPTH_FULL);
    assign empty = (fifo_count == '0);
    assign count = 8'(fifo_count);
    assign busy  = (state != IDLE);
    assign tx    = tx_reg;

    // full is judged on the pre-pop count, so a push while full is dropped even if a pop coincides
    assign push_ok = push && !full;
    // the serializer only takes a byte from IDLE, giving one idle cycle between frames
    assign pop     = (state == IDLE) && !empty;

    // FIFO storage; not reset, the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of 2
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // serializer: start bit, 8 data bits LSB first, stop bit; tx is registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx_reg    <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_reg   <= 1'b1;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (!empty) begin
                        shift_reg <= fifo_mem[rd_ptr];
                        tx_reg    <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        tx_reg   <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_reg <= 1'b1;
                            state  <= STOP;
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            tx_reg    <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_reg <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/data_bus.sv
// rtl/data_bus.sv - cpu data bus: decode, RAM, UART registers, optional cycle counter (DATA_BUS_CYCLE_COUNTER_EN)
module data_bus
    import data_bus_pkg::*;
#(
    parameter int RAM_WORDS    = 1024,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] data_mem_addr,
    input  logic        data_mem_write_enable,
    input  logic [31:0] data_mem_write_data,
    output logic [31:0] data_mem_read_data,
    output logic        uart_tx
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam logic [29:0] RAM_LIMIT = 30'(RAM_WORDS);

    logic [31:0] ram [RAM_WORDS];

    logic       sel_ram;
    logic       sel_data;
    logic       sel_stat;
    logic       uart_push;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_busy;
    logic [7:0] tx_count;
    logic       overflow;

    assign sel_ram   = !data_mem_addr[29] && (data_mem_addr < RAM_LIMIT);
    assign sel_data  = (data_mem_addr == UART_DATA_ADDR);
    assign sel_stat  = (data_mem_addr == UART_STAT_ADDR);
    assign uart_push = data_mem_write_enable && sel_data;

    data_bus_uart_tx #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .clk       (clk),
        .rst       (rst),
        .push      (uart_push),
        .push_data (data_mem_write_data[7:0]),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count),
        .busy      (tx_busy),
        .tx        (uart_tx)
    );

    // RAM write port; contents are not reset
    always_ff @(posedge clk) begin
        if (data_mem_write_enable && sel_ram) begin
            ram[data_mem_addr[AW-1:0]] <= data_mem_write_data;
        end
    end

    // sticky overflow: a dropped push sets it, a status write clears it, set wins on collision
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (uart_push && tx_full) begin
            overflow <= 1'b1;
        end else if (data_mem_write_enable && sel_stat) begin
            overflow <= 1'b0;
        end
    end

`ifdef DATA_BUS_CYCLE_COUNTER_EN
    logic [31:0] cycle_count;
    logic        sel_cycles;

    assign sel_cycles = (data_mem_addr == CYCLES_ADDR);

    // free-running cycle counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

    // zero-latency read mux; anything not decoded reads as 0
    always_comb begin
        data_mem_read_data = '0;
        if (sel_ram) begin
            data_mem_read_data = ram[data_mem_addr[AW-1:0]];
        end else if (sel_stat) begin
            data_mem_read_data[STAT_BUSY]  = tx_busy;
            data_mem_read_data[STAT_EMPTY] = tx_empty;
            data_mem_read_data[STAT_FULL]  = tx_full;
            data_mem_read_data[STAT_OVF]   = overflow;
            data_mem_read_data[15:8]       = tx_count;
        end
`ifdef DATA_BUS_CYCLE_COUNTER_EN
        else if (sel_cycles) begin
            data_mem_read_data = cycle_count;
        end
`endif
    end

endmodule

// File: tb/tb_data_bus.sv
// tb/tb_data_bus.sv - self-checking bench for data_bus against a frame-timeline model
module tb_data_bus;
    import data_bus_pkg::*;

    localparam int RAM_W = 1024;
    localparam int DEPTH = 8;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        tx;

    data_bus #(
        .RAM_WORDS    (RAM_W),
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .data_mem_addr         (addr),
        .data_mem_write_enable (we),
        .data_mem_write_data   (wd),
        .data_mem_read_data    (rd),
        .uart_tx               (tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit checking = 0;

    // model: RAM contents, queued bytes, and the active frame as a start time on a cycle timeline
    logic [31:0] mram [int];
    logic [7:0]  mq [$];
    int          mt     = 0;
    int          fstart = -1;
    logic [7:0]  fbyte  = 8'h00;
    bit          movf   = 0;
    logic [31:0] mcyc   = 32'd0;
    logic        tx_log [$];

    function automatic bit m_busy();
        return (fstart >= 0) && (mt >= fstart) && (mt < fstart + FRAME);
    endfunction

    function automatic logic m_tx();
        int k;
        if (!m_busy()) return 1'b1;
        k = (mt - fstart) / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return fbyte[k-1];
    endfunction

    function automatic logic [31:0] m_stat();
        logic [31:0] s;
        s = 32'd0;
        s[STAT_BUSY]  = m_busy();
        s[STAT_EMPTY] = (mq.size() == 0);
        s[STAT_FULL]  = (mq.size() == DEPTH);
        s[STAT_OVF]   = movf;
        s[15:8]       = 8'(mq.size());
        return s;
    endfunction

    function automatic bit m_read(input logic [29:0] a, output logic [31:0] v);
        v = 32'd0;
        if (!a[29] && a < 30'(RAM_W)) begin
            if (mram.exists(int'(a))) begin
                v = mram[int'(a)];
                return 1;
            end
            return 0;
        end
        if (a == UART_STAT_ADDR) v = m_stat();
`ifdef DATA_BUS_CYCLE_COUNTER_EN
        if (a == CYCLES_ADDR) v = mcyc;
`endif
        return 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic compare();
        logic [31:0] v;
        check("uart_tx", {31'd0, tx}, {31'd0, m_tx()});
        if (m_read(addr, v)) check("read_data", rd, v);
    endtask

    task automatic model_step();
        int pre;
        bit ovf_set;
        if (we && !addr[29] && addr < 30'(RAM_W)) mram[int'(addr)] = wd;
        if (rst) begin
            mq.delete();
            fstart = -1;
            movf   = 0;
            mcyc   = 32'd0;
            mt++;
            return;
        end
        pre     = mq.size();
        ovf_set = 0;
        if (!m_busy() && pre > 0) begin
            fbyte  = mq.pop_front();
            fstart = mt + 1;
        end
        if (we && addr == UART_DATA_ADDR) begin
            if (pre >= DEPTH) ovf_set = 1;
            else mq.push_back(wd[7:0]);
        end
        if (ovf_set) movf = 1;
        else if (we && addr == UART_STAT_ADDR) movf = 0;
        mcyc = mcyc + 32'd1;
        mt++;
    endtask

    task automatic tick();
        #1;
        if (checking) compare();
        model_step();
        @(posedge clk);
        #1;
        tx_log.push_back(tx);
    endtask

    task automatic idle(input int n);
        we   = 1'b0;
        addr = UART_STAT_ADDR;
        repeat (n) tick();
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] d);
        we   = 1'b1;
        addr = a;
        wd   = d;
        tick();
        we   = 1'b0;
        addr = UART_STAT_ADDR;
    endtask

    task automatic rd_lit(input logic [29:0] a, input logic [31:0] exp, input string name);
        we   = 1'b0;
        addr = a;
        #1;
        check(name, rd, exp);
        tick();
        addr = UART_STAT_ADDR;
    endtask

    initial begin
        logic [9:0]  a5_frame;
        logic [31:0] c1, c2;
        int          errs;

        rst  = 1'b1;
        we   = 1'b0;
        addr = UART_STAT_ADDR;
        wd   = 32'd0;
        repeat (3) tick();
        rst      = 1'b0;
        checking = 1;

        // reset state
        #1;
        check("reset_stat", rd, 32'h0000_0002);
        check("reset_tx", {31'd0, tx}, 32'd1);

        // RAM, unmapped space, boundaries, read-old-on-write
        wr(30'd5, 32'hDEAD_BEEF);
        rd_lit(30'd5, 32'hDEAD_BEEF, "ram_rd5");
        rd_lit(30'(RAM_W), 32'd0, "ram_past_end");
        rd_lit(30'h1FFF_FFFF, 32'd0, "unmapped_1fff");
        rd_lit(UART_DATA_ADDR, 32'd0, "uart_data_rd");
        wr(30'(RAM_W - 1), 32'hCAFE_F00D);
        rd_lit(30'(RAM_W - 1), 32'hCAFE_F00D, "ram_last");
        wr(30'h3000_0000, 32'h1111_1111);
        rd_lit(30'h3000_0000, 32'd0, "unmapped_wr");
        wr(30'd5, 32'h1234_5678);
        rd_lit(30'd5, 32'h1234_5678, "ram_overwrite");

        // single byte 0xA5: one idle cycle, then start, LSB-first data, stop
        tx_log.delete();
        wr(UART_DATA_ADDR, 32'h0000_00A5);
        idle(46);
        a5_frame = 10'b1_1010_0101_0;
        errs = 0;
        if (tx_log[0] !== 1'b1) errs++;
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < CPB; j++)
                if (tx_log[1 + k*CPB + j] !== a5_frame[k]) errs++;
        for (int i = 41; i < 46; i++)
            if (tx_log[i] !== 1'b1) errs++;
        check("a5_waveform_errs", errs, 0);

        // back-to-back frames: stop, one idle-high cycle, next start
        tx_log.delete();
        wr(UART_DATA_ADDR, 32'h0000_0055);
        wr(UART_DATA_ADDR, 32'h0000_000F);
        idle(90);
        check("b2b_gap", {27'd0, tx_log[36], tx_log[37], tx_log[40], tx_log[41], tx_log[42]},
              {27'd0, 5'b01110});

        // FIFO fill and overflow
        for (int i = 0; i < 10; i++) wr(UART_DATA_ADDR, 32'(i));
        rd_lit(UART_STAT_ADDR, 32'h0000_080D, "ovf_stat");
        wr(UART_STAT_ADDR, 32'hFFFF_FFFF);
        rd_lit(UART_STAT_ADDR, 32'h0000_0805, "ovf_cleared");
        idle(9 * (FRAME + 1) + 10);
        rd_lit(UART_STAT_ADDR, 32'h0000_0002, "drained_stat");

        // reset during data bit 3 with two bytes still queued
        wr(UART_DATA_ADDR, 32'h0000_003C);
        wr(UART_DATA_ADDR, 32'h0000_00C3);
        wr(UART_DATA_ADDR, 32'h0000_0099);
        idle(16);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_tx_high", {31'd0, tx}, 32'd1);
        rd_lit(UART_STAT_ADDR, 32'h0000_0002, "rst_stat");
        idle(60);

        // cycle counter
        we   = 1'b0;
        addr = CYCLES_ADDR;
        #1;
        c1 = rd;
        repeat (10) tick();
        #1;
        c2 = rd;
`ifdef DATA_BUS_CYCLE_COUNTER_EN
        check("cycles_delta", c2 - c1, 32'd10);
`else
        check("cycles_zero_a", c1, 32'd0);
        check("cycles_zero_b", c2, 32'd0);
`endif
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
